cipher: RTL and testbench
=========================

# cipher

Iterative AES-128 forward cipher: encrypts one 128-bit block in 11 clock edges, one round per cycle, with the key schedule expanded on the fly. It is the encrypt-side counterpart of the inverse cipher in the AES accelerator. It accepts a plaintext/key pair on a start pulse and presents the ciphertext plus the final round key, so the decrypt path can start its reverse key schedule without re-expanding.

## Interface
- No parameters. The block is AES-128 only: Nk = 4, Nr = 10, fixed.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to encrypt; sampled only when busy = 0
- key  in  128  cipher key; key[127:120] = key byte 0 (FIPS-197 order)
- in  in  128  plaintext; in[127:120] = s(0,0), column-major
- busy  out  1  high while rounds are in progress
- done  out  1  high from completion until the next accepted start or reset
- out  out  128  ciphertext, registered and held
- lastKey  out  128  round key 10 (w[40..43]), valid while done = 1

## Operation
- State machine has three states: IDLE, RUN, DONE.
  - Reset forces IDLE.
  - IDLE or DONE with start = 1 goes to RUN.
  - RUN with round = 10 goes to DONE.
  - Otherwise the state holds.
- Accept edge (start = 1 while not busy):
  - stm <= in ^ key.
  - rk <= key.
  - rcon <= 8'h01.
  - round <= 1.
  - done <= 0.
- Each RUN edge performs these steps:
  - rkNext = expand(rk, rcon): RotWord, SubWord, XOR rcon into the top byte of the last word, then the chained XOR across the 4 words.
  - For round 1..9: stm <= MixColumns(ShiftRows(SubBytes(stm))) ^ rkNext.
  - For round 10: stm <= ShiftRows(SubBytes(stm)) ^ rkNext, with no MixColumns.
  - rk <= rkNext.
  - rcon <= xtime(rcon), reducing by 8'h1b when bit 7 is set. This gives the sequence 01,02,04,08,10,20,40,80,1b,36.
  - round <= round + 1.
- The round-10 edge also performs:
  - out <= final stm value.
  - lastKey <= rkNext.
  - done <= 1.
  - busy <= 0.
- out and lastKey never show intermediate round values. They hold the previous result through a RUN.
- start while busy = 1 is ignored. key and in are sampled only on the accept edge, so later changes have no effect.
- start on a cycle where done = 1 is accepted on that edge: done drops and out holds until the new result.
- SubBytes uses a combinational S-box, 16 copies for the state plus 4 for the key schedule.

## Timing
- Reset values:
  - busy = 0, done = 0.
  - out = 0, lastKey = 0.
  - internal stm, rk and round = 0.
  - rcon = 8'h01.
  - State = IDLE.
- Latency: the accept edge is edge 0. busy = 1 after edge 0. done = 1 and out are valid after edge 10.
- Throughput: one block per 11 edges. Back-to-back operation is possible by holding start high.
- Reset asserted mid-RUN:
  - Returns to IDLE on that edge with all outputs at reset values.
  - The partial result is discarded.
  - start in the same cycle as reset is ignored.
- The round counter is 4 bits and never exceeds 10. Values 11-15 are unreachable; if reached, the block returns to IDLE.

## Test plan
- FIPS-197 App. B vector:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, in 3243f6a8885a308d313198a2e0370734, start one cycle.
  - Required: out = 3925841d02dc09fbdc118597196a0b32 and lastKey = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: done rises exactly 10 edges after the accept edge, and busy is high for exactly those 10 cycles.
- FIPS-197 App. C.1 vector:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, in 00112233445566778899aabbccddeeff.
  - Required: out = 69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero vector:
  - Stimulus: key and plaintext both 0.
  - Required: out = 66e94bd4ef8a2c3b884cfa59ca342b2e.
- Start during busy:
  - Stimulus: run the App. B vector; at edge 4, pulse start with the C.1 key and data.
  - Required: out is still the App. B ciphertext, and done rises at edge 10 only.
- Reset mid-operation:
  - Stimulus: assert reset at edge 6 of the App. B run, release it, then start the C.1 vector.
  - Required: out = 0 and done = 0 immediately after reset.
  - Required: the C.1 ciphertext appears 10 edges after its accept edge.
- Back-to-back runs:
  - Stimulus: hold start high across two runs (App. B, then C.1, switching in and key when done rises).
  - Required: done drops on the second accept edge, and out holds the App. B result until it becomes the C.1 result 10 edges later.

Source files
------------

// File: rtl/cipher_if.sv
// Handshake and data bundle for the AES-128 forward cipher.
// The requester drives start/key/in; the cipher returns status and results.
interface cipher_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] in;
  logic         busy;
  logic         done;
  logic [127:0] out;
  logic [127:0] lastKey;

  modport master (
    output start, key, in,
    input  busy, done, out, lastKey
  );

  modport slave (
    input  start, key, in,
    output busy, done, out, lastKey
  );
endinterface

// File: rtl/cipher.sv
// Iterative AES-128 encryptor: one round per clock with on-the-fly key expansion.
// Presents the ciphertext and round key 10 so decryption can run its schedule backwards.
module cipher (
  input logic     clk,
  input logic     reset,
  cipher_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] stm_q, stm_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_q, out_d;
  logic [127:0] last_q, last_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] rk_next;
  logic [127:0] round_res;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte n = 4*col + row sits at bits [127-8n -: 8].
  function automatic logic [127:0] do_round(input logic [127:0] st, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int n = 0; n < 16; n++) s[n] = sbox(st[127-8*n -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) t[4*c+rw] = s[4*((c+rw)%4)+rw];
    end
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c];
        a1 = t[4*c+1];
        a2 = t[4*c+2];
        a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int n = 0; n < 16; n++) r[127-8*n -: 8] = t[n];
    return r ^ k;
  endfunction

  assign rk_next   = expand(rk_q, rcon_q);
  assign round_res = do_round(stm_q, rk_next, round_q == 4'd10);

  always_comb begin
    state_d = state_q;
    stm_d   = stm_q;
    rk_d    = rk_q;
    out_d   = out_q;
    last_d  = last_q;
    rcon_d  = rcon_q;
    round_d = round_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          stm_d   = bus.in ^ bus.key;
          rk_d    = bus.key;
          rcon_d  = 8'h01;
          round_d = 4'd1;
        end
      end
      StRun: begin
        if (round_q == 4'd0 || round_q > 4'd10) begin
          state_d = StIdle;
        end else begin
          stm_d  = round_res;
          rk_d   = rk_next;
          rcon_d = xtime(rcon_q);
          if (round_q == 4'd10) begin
            // Counter parks at 10 so it never leaves the legal range.
            state_d = StDone;
            out_d   = round_res;
            last_d  = rk_next;
          end else begin
            round_d = round_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      stm_q   <= '0;
      rk_q    <= '0;
      out_q   <= '0;
      last_q  <= '0;
      rcon_q  <= 8'h01;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      stm_q   <= stm_d;
      rk_q    <= rk_d;
      out_q   <= out_d;
      last_q  <= last_d;
      rcon_q  <= rcon_d;
      round_q <= round_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.out     = out_q;
  assign bus.lastKey = last_q;

endmodule

// File: tb/tb_cipher.sv
// Bench for cipher: known-answer table, hand-written protocol corners and random
// blocks compared against a byte-array AES model built from log/antilog tables.
module tb_cipher;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cipher_if bus ();

  cipher dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] sb [256];

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [127:0] lk;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x >= 256) x = x ^ 'h11b;
    end
    return 8'(p);
  endfunction

  // S-box from exp/log tables of generator 3, then the FIPS affine map.
  function automatic void build_sbox();
    int ex [256];
    int lg [256];
    int inv, b;
    ex[0] = 1;
    for (int i = 1; i < 256; i++) ex[i] = int'(m_mul(8'(ex[i-1]), 8'h03));
    for (int i = 0; i < 255; i++) lg[ex[i]] = i;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 0 : ex[(255 - lg[x]) % 255];
      b = 0;
      for (int i = 0; i < 8; i++) begin
        if ((((inv >> i) ^ (inv >> ((i + 4) % 8)) ^ (inv >> ((i + 5) % 8)) ^
              (inv >> ((i + 6) % 8)) ^ (inv >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1) != 0)
          b = b | (1 << i);
      end
      sb[x] = 8'(b);
    end
  endfunction

  function automatic void aes_model(input logic [127:0] k, input logic [127:0] p,
                                    output logic [127:0] ct, output logic [127:0] lk);
    logic [31:0] w [44];
    logic [7:0]  rc [10];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0)
        tmp = {sb[tmp[23:16]] ^ rc[i/4-1], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]};
      w[i] = w[i-4] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = p[127-8*n -: 8] ^ k[127-8*n -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = sb[s[4*((c+r)%4)+r]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[4*c+r] = m_mul(t[4*c+r], 8'h02) ^ m_mul(t[4*c+(r+1)%4], 8'h03)
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
        end
      for (int c = 0; c < 4; c++) begin
        tmp = w[4*rnd+c];
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ tmp[31-8*r -: 8];
      end
    end
    for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
    lk = {w[40], w[41], w[42], w[43]};
  endfunction

  // Called at the negedge after an accept edge; counts edges until done appears.
  task automatic wait_done(output int edges, output int busy_cnt, output bit changed);
    logic [127:0] o;
    o = bus.out;
    edges = 0;
    busy_cnt = 0;
    changed = 1'b0;
    while (!bus.done && edges < 30) begin
      if (bus.busy) busy_cnt++;
      if (bus.out !== o) changed = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic do_run(input logic [127:0] k, input logic [127:0] p,
                        output int edges, output int busy_cnt, output bit changed);
    @(negedge clk);
    bus.start = 1'b1;
    bus.key   = k;
    bus.in    = p;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, busy_cnt, changed);
  endtask

  initial begin
    int e, bc, e2, bc2;
    bit ch, ch2;
    logic [127:0] rk, rp, mct, mlk;

    build_sbox();
    vecs[0] = '{"appB", 128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{"appC1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{"zero", 128'h0, 128'h0,
                128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.key = '0;
    bus.in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset out", bus.out, 0);
    check("reset lastKey", bus.lastKey, 0);
    reset = 1'b0;

    for (int i = 0; i < 3; i++) begin
      do_run(vecs[i].key, vecs[i].pt, e, bc, ch);
      check({vecs[i].name, " out"}, bus.out, vecs[i].ct);
      check({vecs[i].name, " lastKey"}, bus.lastKey, vecs[i].lk);
      check({vecs[i].name, " latency"}, e, 10);
      check({vecs[i].name, " busy cycles"}, bc, 10);
      check({vecs[i].name, " busy at done"}, bus.busy, 0);
    end

    // start while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.key = vecs[0].key;
    bus.in = vecs[0].pt;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.key = vecs[1].key;
    bus.in = vecs[1].pt;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(e, bc, ch);
    check("busy-start latency", e + 4, 10);
    check("busy-start out", bus.out, vecs[0].ct);
    check("busy-start lastKey", bus.lastKey, vecs[0].lk);

    // reset at edge 6, with start asserted alongside it
    @(negedge clk);
    bus.start = 1'b1;
    bus.key = vecs[0].key;
    bus.in = vecs[0].pt;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    bus.start = 1'b1;
    bus.key = vecs[1].key;
    bus.in = vecs[1].pt;
    @(posedge clk);
    @(negedge clk);
    check("midreset out", bus.out, 0);
    check("midreset done", bus.done, 0);
    check("midreset busy", bus.busy, 0);
    check("midreset lastKey", bus.lastKey, 0);
    reset = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("start with reset ignored", bus.busy, 0);
    do_run(vecs[1].key, vecs[1].pt, e, bc, ch);
    check("post-reset latency", e, 10);
    check("post-reset out", bus.out, vecs[1].ct);

    // back-to-back with start held high
    @(negedge clk);
    bus.start = 1'b1;
    bus.key = vecs[0].key;
    bus.in = vecs[0].pt;
    @(posedge clk);
    @(negedge clk);
    wait_done(e, bc, ch);
    check("b2b first latency", e, 10);
    check("b2b first out", bus.out, vecs[0].ct);
    bus.key = vecs[1].key;
    bus.in = vecs[1].pt;
    @(posedge clk);
    @(negedge clk);
    check("b2b done drop", bus.done, 0);
    check("b2b busy again", bus.busy, 1);
    check("b2b out held at accept", bus.out, vecs[0].ct);
    wait_done(e2, bc2, ch2);
    bus.start = 1'b0;
    check("b2b out held during run", ch2, 0);
    check("b2b second latency", e2, 10);
    check("b2b second out", bus.out, vecs[1].ct);
    check("b2b second lastKey", bus.lastKey, vecs[1].lk);

    for (int i = 0; i < 20; i++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      aes_model(rk, rp, mct, mlk);
      do_run(rk, rp, e, bc, ch);
      check($sformatf("rand%0d out", i), bus.out, mct);
      check($sformatf("rand%0d lastKey", i), bus.lastKey, mlk);
      check($sformatf("rand%0d latency", i), e, 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
